// File: rtl/test_sequencer.sv
// test_sequencer: runs the selected self-test channels one at a time in
// ascending index order through each engine's init/progress/result
// handshake. It enforces a start window and a run timeout per channel and
// keeps sticky pass/fail/timeout bitmaps for the message updater.
//
// Optional build macro TESTSEQ_LOOP_EN adds the `loop` input and the
// `loop_count` output. With loop=1, a run in which every channel passes
// is repeated automatically.
//
// Debug visibility: state_q holds the FSM state and can be probed
// hierarchically.
module test_sequencer #(
    parameter int NCHAN     = 4,
    parameter int INIT_CYC  = 4,
    parameter int START_WIN = 16,
    parameter int TIMEOUT   = 7000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NCHAN-1:0] start_mask,
    output logic [NCHAN-1:0] test_init,
    input  logic [NCHAN-1:0] test_progress,
    input  logic [NCHAN-1:0] test_result,
    output logic             busy,
    output logic [3:0]       cur_chan,
    output logic [NCHAN-1:0] pass_mask,
    output logic [NCHAN-1:0] fail_mask,
    output logic [NCHAN-1:0] timeout_mask,
`ifdef TESTSEQ_LOOP_EN
    input  logic             loop,
    output logic [15:0]      loop_count,
`endif
    output logic             done
);

    // One shared cycle counter. It is sized for the longest interval it has
    // to measure.
    localparam int MAX_A = (TIMEOUT > START_WIN) ? TIMEOUT : START_WIN;
    localparam int MAX_C = (MAX_A > INIT_CYC) ? MAX_A : INIT_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        IDLE, SCAN, INIT, WAITRUN, RUN, COLLECT, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [NCHAN-1:0] pending_q, pending_d;
    logic [3:0]       cur_chan_q, cur_chan_d;
    logic [NCHAN-1:0] pass_q, pass_d, fail_q, fail_d, to_q, to_d;
    logic [NCHAN-1:0] cur_sel;
    logic [3:0]       low_idx;
    logic             prog_cur, res_cur;
`ifdef TESTSEQ_LOOP_EN
    logic [NCHAN-1:0] latched_q, latched_d;
    logic [15:0]      loop_cnt_q, loop_cnt_d;
`endif

    // One-hot select of the serviced channel. Using a select vector avoids
    // out-of-range indexing when NCHAN is small.
    assign cur_sel  = NCHAN'(1) << cur_chan_q;
    assign prog_cur = |(test_progress & cur_sel);
    assign res_cur  = |(test_result & cur_sel);
    // The counter saturates, so it can never wrap.
    assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Find the lowest pending channel. Scanning downward lets the lowest
    // set bit be the last one assigned.
    always_comb begin
        low_idx = 4'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = 4'(i);
        end
    end

    // Compute the next state and the decoded outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        cur_chan_d = cur_chan_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        to_d       = to_q;
`ifdef TESTSEQ_LOOP_EN
        latched_d  = latched_q;
        loop_cnt_d = loop_cnt_q;
`endif
        test_init  = '0;
        done       = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d = start_mask;
                    pass_d    = '0;
                    fail_d    = '0;
                    to_d      = '0;
`ifdef TESTSEQ_LOOP_EN
                    latched_d  = start_mask;
                    loop_cnt_d = '0;
`endif
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (pending_q == '0) begin
                    state_d = DONE;
                end else begin
                    cur_chan_d = low_idx;
                    cnt_d      = '0;
                    state_d    = INIT;
                end
            end
            INIT: begin
                test_init = cur_sel;
                if (cnt_q == CW'(INIT_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = WAITRUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAITRUN: begin
                if (prog_cur) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (cnt_q == CW'(START_WIN - 1)) begin
                    // The engine never showed busy; it is taken as already finished.
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                // A progress fall takes priority over a timeout in the same cycle.
                if (!prog_cur) begin
                    state_d = COLLECT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    to_d      = to_q | cur_sel;
                    pending_d = pending_q & ~cur_sel;
                    state_d   = SCAN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            COLLECT: begin
                if (res_cur) pass_d = pass_q | cur_sel;
                else         fail_d = fail_q | cur_sel;
                pending_d = pending_q & ~cur_sel;
                state_d   = SCAN;
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b0;
                state_d = IDLE;
`ifdef TESTSEQ_LOOP_EN
                if (loop && ((fail_q | to_q) == '0)) begin
                    busy       = 1'b1;
                    loop_cnt_d = (loop_cnt_q == 16'hFFFF) ? loop_cnt_q : loop_cnt_q + 16'd1;
                    pending_d  = latched_q;
                    pass_d     = '0;
                    fail_d     = '0;
                    to_d       = '0;
                    state_d    = SCAN;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and datapath registers, with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            cur_chan_q <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            to_q       <= '0;
`ifdef TESTSEQ_LOOP_EN
            latched_q  <= '0;
            loop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            cur_chan_q <= cur_chan_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            to_q       <= to_d;
`ifdef TESTSEQ_LOOP_EN
            latched_q  <= latched_d;
            loop_cnt_q <= loop_cnt_d;
`endif
        end
    end

    assign cur_chan     = cur_chan_q;
    assign pass_mask    = pass_q;
    assign fail_mask    = fail_q;
    assign timeout_mask = to_q;
`ifdef TESTSEQ_LOOP_EN
    assign loop_count   = loop_cnt_q;
`endif

endmodule
